// File: rtl/lu_rr_scheduler.sv
// Round-robin scheduler sharing one AND/NAND logic unit between two valid/ready requesters.
// Grants alternate under contention; each operation's result is returned with its requester ID.
module lu_rr_scheduler #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned LU_LATENCY = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_select,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_select,
    output logic             req1_ready,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic             lu_select,
    input  logic [WIDTH-1:0] lu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt,
    output logic             busy
);

    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [LAT_W-1:0] lat_cnt;
    logic             grant0;
    logic             grant1;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
            lu_a       <= '0;
            lu_b       <= '0;
            lu_select  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            done0_cnt  <= '0;
            done1_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        lu_a       <= req0_a;
                        lu_b       <= req0_b;
                        lu_select  <= req0_select;
                        rsp_id     <= 1'b0;
                        last_grant <= 1'b0;
                        lat_cnt    <= LAT_W'(LU_LATENCY - 1);
                        state      <= EXEC;
                    end else if (grant1) begin
                        lu_a       <= req1_a;
                        lu_b       <= req1_b;
                        lu_select  <= req1_select;
                        rsp_id     <= 1'b1;
                        last_grant <= 1'b1;
                        lat_cnt    <= LAT_W'(LU_LATENCY - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        rsp_data  <= lu_result;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (rsp_id) begin
                            done1_cnt <= done1_cnt + CNT_W'(1);
                        end else begin
                            done0_cnt <= done0_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
